// File: rtl/seven_bit_vector_reverse.sv
// seven_bit_vector_reverse: registered bit-order reverser, one-stage ready/valid.
//   in_vector/in_valid/in_ready : upstream word + handshake (mode sampled with it)
//   out_vector/out_valid/out_ready : reordered word + handshake
//   out_palin : captured word equals its own full bit reversal
module seven_bit_vector_reverse #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_vector,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out_vector,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_palin
);

  localparam int unsigned H = WIDTH / 2;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    M_REVERSE  = 2'b00,
    M_PASS     = 2'b01,
    M_HALFSWAP = 2'b10,
    M_HALFREV  = 2'b11
  } mode_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             palin_q, palin_d;

  logic [WIDTH-1:0] full_rev;
  logic [WIDTH-1:0] half_rev;
  logic [WIDTH-1:0] xformed;
  logic             accept;

  always_comb begin
    full_rev = '0;
    half_rev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      full_rev[i] = in_vector[WIDTH-1-i];
    end
    for (int unsigned i = 0; i < H; i++) begin
      half_rev[i]     = in_vector[H-1-i];
      half_rev[H + i] = in_vector[WIDTH-1-i];
    end
  end

  always_comb begin
    xformed = in_vector;
    case (mode_e'(mode))
      M_REVERSE:  xformed = full_rev;
      M_PASS:     xformed = in_vector;
      M_HALFSWAP: xformed = {in_vector[H-1:0], in_vector[WIDTH-1:H]};
      M_HALFREV:  xformed = half_rev;
      default:    xformed = in_vector;
    endcase
  end

  assign in_ready = (state_q == S_EMPTY) || out_ready;
  assign accept   = in_valid && in_ready;

  // Data and flag only load on accept, so they hold across drain and stall.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    palin_d = palin_q;
    if (accept) begin
      state_d = S_FULL;
      vec_d   = xformed;
      palin_d = (in_vector == full_rev);
    end else if (out_ready) begin
      state_d = S_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      vec_q   <= '0;
      palin_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      palin_q <= palin_d;
    end
  end

  assign out_valid  = (state_q == S_FULL);
  assign out_vector = vec_q;
  assign out_palin  = palin_q;

endmodule

// File: tb/tb_seven_bit_vector_reverse.sv
module tb_seven_bit_vector_reverse;

  localparam int W = 8;
  localparam int H = W / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] in_vector;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [W-1:0] out_vector;
  logic         out_valid;
  logic         out_ready;
  logic         out_palin;

  int n_checks = 0;
  int n_fail   = 0;

  seven_bit_vector_reverse #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_vector  (in_vector),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .out_vector (out_vector),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_palin  (out_palin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference transform expressed as a source-index permutation per output bit.
  function automatic logic [W-1:0] model_f(input logic [1:0] m, input logic [W-1:0] x);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00:   src = W - 1 - i;
        2'b01:   src = i;
        2'b10:   src = (i + H) % W;
        default: src = (i < H) ? (H - 1 - i) : (W - 1 + H - i);
      endcase
      r[i] = x[src];
    end
    return r;
  endfunction

  function automatic logic model_palin(input logic [W-1:0] x);
    return x == model_f(2'b00, x);
  endfunction

  logic         m_valid;
  logic [W-1:0] m_vec;
  logic         m_palin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0;
      m_vec   = '0;
      m_palin = 1'b0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        m_vec   = model_f(mode, in_vector);
        m_palin = model_palin(in_vector);
        m_valid = 1'b1;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cmp_in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("cmp_out_vector", 32'(out_vector), 32'(m_vec));
    chk("cmp_out_palin", 32'(out_palin), 32'(m_palin));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [1:0] m, input logic r);
    in_valid  = v;
    in_vector = d;
    mode      = m;
    out_ready = r;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         p;
  } vec_t;

  vec_t b2b[4];
  vec_t modes[4];
  vec_t pals[3];

  initial begin
    b2b[0] = '{2'b00, 8'b01010101, 8'b10101010, 1'b0};
    b2b[1] = '{2'b00, 8'b11110000, 8'b00001111, 1'b0};
    b2b[2] = '{2'b00, 8'b00001111, 8'b11110000, 1'b0};
    b2b[3] = '{2'b00, 8'b11001100, 8'b00110011, 1'b0};
    modes[0] = '{2'b01, 8'b11010010, 8'b11010010, 1'b0};
    modes[1] = '{2'b10, 8'b11010010, 8'b00101101, 1'b0};
    modes[2] = '{2'b11, 8'b11010010, 8'b10110100, 1'b0};
    modes[3] = '{2'b00, 8'b11010010, 8'b01001011, 1'b0};
    pals[0] = '{2'b00, 8'b10000001, 8'b10000001, 1'b1};
    pals[1] = '{2'b00, 8'b11001100, 8'b00110011, 1'b0};
    pals[2] = '{2'b00, 8'b10100101, 8'b10100101, 1'b1};

    rst_n = 1'b0;
    drive(1'b0, '0, 2'b00, 1'b0);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_vector", 32'(out_vector), 32'd0);
    chk("reset_out_palin", 32'(out_palin), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    #22 rst_n = 1'b1;
    step();

    // Back-to-back, mode 00
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, b2b[i].x, b2b[i].m, 1'b1);
      step();
      chk($sformatf("b2b_vec%0d", i), 32'(out_vector), 32'(b2b[i].y));
      chk($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 8'hA5, 2'b10, 1'b1);
    step();
    chk("b2b_drain", 32'(out_valid), 32'd0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, modes[i].x, modes[i].m, 1'b1);
      step();
      chk($sformatf("mode_%0d", i), 32'(out_vector), 32'(modes[i].y));
    end

    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pals[i].x, pals[i].m, 1'b1);
      step();
      chk($sformatf("palin_flag%0d", i), 32'(out_palin), 32'(pals[i].p));
      chk($sformatf("palin_vec%0d", i), 32'(out_vector), 32'(pals[i].y));
    end

    // Idle with garbage on the data path must not disturb outputs
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'($urandom), 2'($urandom), 1'b1);
      step();
    end
    chk("idle_hold_vec", 32'(out_vector), 32'(8'b10100101));
    chk("idle_valid", 32'(out_valid), 32'd0);

    // Backpressure
    drive(1'b1, 8'b11110000, 2'b00, 1'b0);
    step();
    chk("bp_accept_vec", 32'(out_vector), 32'(8'b00001111));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, (i % 2 == 0) ? 8'b01010101 : 8'b10011001, 2'(i + 1), 1'b0);
      #1;
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
      step();
      chk($sformatf("bp_hold_vec%0d", i), 32'(out_vector), 32'(8'b00001111));
      chk($sformatf("bp_hold_valid%0d", i), 32'(out_valid), 32'd1);
    end
    drive(1'b0, 8'hFF, 2'b01, 1'b1);
    step();
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_vec", 32'(out_vector), 32'(8'b00001111));

    // Async reset while holding a result
    drive(1'b1, 8'b10000001, 2'b00, 1'b0);
    step();
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_palin", 32'(out_palin), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_vec", 32'(out_vector), 32'd0);
    chk("async_palin", 32'(out_palin), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    #10 rst_n = 1'b1;
    drive(1'b1, 8'b00000001, 2'b00, 1'b1);
    step();
    chk("post_reset_vec", 32'(out_vector), 32'(8'b10000000));
    chk("post_reset_valid", 32'(out_valid), 32'd1);
    drive(1'b0, '0, 2'b00, 1'b1);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
